// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair for the Ex stage.
// Results are computed when the operation is accepted and held until the busy window expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        mdStall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | no operation in flight; mult/div/mthi/mtlo accepted
  // RUN   | result pending; counter runs N..1, commit on the edge leaving 1
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, stateNext;
  logic [4:0]  count;
  logic [31:0] pendHi, pendLo;
  logic        pendWe;

  logic isMul, isDiv, isMd, accept, commit;
  logic signedDiv, negA, negB;
  logic [31:0] magA, magB, divisor, uQ, uR, quot, rem;
  logic signed [63:0] sProd;
  logic [63:0] uProd, result;

  assign isMul   = (mdOp == 3'd1) || (mdOp == 3'd2);
  assign isDiv   = (mdOp == 3'd3) || (mdOp == 3'd4);
  assign isMd    = isMul || isDiv;
  assign busy    = (state == RUN);
  assign mdStall = busy || (start && isMd);

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (start && isMd) begin
        accept    = 1'b1;
        stateNext = RUN;
      end
      RUN: if (count == 5'd1) begin
        commit    = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  always_comb begin
    signedDiv = (mdOp == 3'd3);
    negA      = signedDiv && srcA[31];
    negB      = signedDiv && srcB[31];
    magA      = negA ? (32'd0 - srcA) : srcA;
    magB      = negB ? (32'd0 - srcB) : srcB;
    divisor   = (magB == 32'd0) ? 32'd1 : magB;
    uQ        = magA / divisor;
    uR        = magA % divisor;
    quot      = (negA ^ negB) ? (32'd0 - uQ) : uQ;
    rem       = negA ? (32'd0 - uR) : uR;
    sProd     = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
    uProd     = {32'd0, srcA} * {32'd0, srcB};
    result    = 64'd0;
    case (mdOp)
      3'd1:    result = sProd;
      3'd2:    result = uProd;
      3'd3,
      3'd4:    result = {rem, quot};
      default: result = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 5'd0;
      pendHi <= 32'd0;
      pendLo <= 32'd0;
      pendWe <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else if (accept) begin
      count  <= isMul ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
      pendHi <= result[63:32];
      pendLo <= result[31:0];
      pendWe <= !(isDiv && (srcB == 32'd0));
    end else if (busy) begin
      count <= count - 5'd1;
      if (commit && pendWe) begin
        hi <= pendHi;
        lo <= pendLo;
      end
    end else if (start) begin
      if (mdOp == 3'd5) hi <= srcA;
      if (mdOp == 3'd6) lo <= srcA;
    end
  end

endmodule
